// File: rtl/adc_sampler_ctrl.sv
// Sampling controller for the amp + ADC front end: programs amp gain, paces ADC conversions
// at a runtime period and averages 2**AVG_LOG2 samples per channel into registered results.
module adc_sampler_ctrl #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                CLK50MHZ,
  input  logic                RST,
  input  logic                run,
  input  logic                single,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          gain_a,
  input  logic [3:0]          gain_b,
  input  logic                gain_upd,
  output logic                amp_trig,
  output logic [3:0]          amp_a,
  output logic [3:0]          amp_b,
  input  logic                amp_done,
  output logic                adc_trig,
  input  logic                adc_done,
  input  logic [13:0]         adc_a,
  input  logic [13:0]         adc_b,
  output logic [13:0]         sample_a,
  output logic [13:0]         sample_b,
  output logic                sample_valid,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned SumW = 14 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LastSmp = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    StAmpLoad, StAmpWait, StIdle, StCntWait, StAdcStart, StAdcWait
  } state_e;

  state_e                    state_q;
  logic [PERIOD_W-1:0]       per_cnt_q;
  logic [AVG_LOG2:0]         smp_cnt_q;
  logic signed [SumW-1:0]    sum_a_q, sum_b_q;
  logic                      gain_pend_q, single_pend_q;

  logic [PERIOD_W-1:0]       period_eff;
  logic                      tick, grp_last, gain_req, single_req, do_load;
  logic signed [SumW-1:0]    sum_a_nxt, sum_b_nxt;

  always_comb begin
    period_eff = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
    // >= so that shrinking the period mid-count still produces a tick
    tick       = per_cnt_q >= (period_eff - PERIOD_W'(1));
    sum_a_nxt  = sum_a_q + SumW'($signed(adc_a));
    sum_b_nxt  = sum_b_q + SumW'($signed(adc_b));
    grp_last   = smp_cnt_q == LastSmp;
    gain_req   = gain_pend_q | gain_upd;
    single_req = single_pend_q | single;
    // A gain reload latches the codes and strobes the amp on the same edge, so the strobe
    // and the new codes appear together one cycle after the decision.
    do_load    = (state_q == StAmpLoad)
               || (((state_q == StIdle) || (state_q == StCntWait)) && gain_req)
               || ((state_q == StAdcWait) && adc_done && gain_req);
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state_q       <= StAmpLoad;
      per_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      sum_a_q       <= '0;
      sum_b_q       <= '0;
      gain_pend_q   <= 1'b0;
      single_pend_q <= 1'b0;
      amp_trig      <= 1'b0;
      amp_a         <= '0;
      amp_b         <= '0;
      adc_trig      <= 1'b0;
      sample_a      <= '0;
      sample_b      <= '0;
      sample_valid  <= 1'b0;
      sample_cnt    <= '0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      amp_trig      <= 1'b0;
      adc_trig      <= 1'b0;
      sample_valid  <= 1'b0;
      busy          <= 1'b1;
      per_cnt_q     <= tick ? '0 : per_cnt_q + 1'b1;
      gain_pend_q   <= gain_req;
      single_pend_q <= single_req;

      unique case (state_q)
        StAmpLoad: state_q <= StAmpWait;

        StAmpWait: begin
          if (amp_done) begin
            per_cnt_q <= '0;
            if (run || single_req) begin
              state_q <= StCntWait;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end

        StIdle: begin
          if (gain_req) begin
            state_q <= StAmpWait;
          end else if (run || single_req) begin
            state_q   <= StCntWait;
            per_cnt_q <= '0;
          end else begin
            busy <= 1'b0;
          end
        end

        StCntWait: begin
          if (gain_req) begin
            state_q <= StAmpWait;
          end else if (!run && !single_req) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            sum_a_q   <= '0;
            sum_b_q   <= '0;
            smp_cnt_q <= '0;
          end else if (tick) begin
            state_q  <= StAdcStart;
            adc_trig <= 1'b1;
          end
        end

        StAdcStart: begin
          if (tick) overrun <= 1'b1;
          state_q <= StAdcWait;
        end

        StAdcWait: begin
          if (tick) overrun <= 1'b1;
          if (adc_done) begin
            if (grp_last) begin
              sample_a      <= 14'(sum_a_nxt >>> AVG_LOG2);
              sample_b      <= 14'(sum_b_nxt >>> AVG_LOG2);
              sample_valid  <= 1'b1;
              sample_cnt    <= sample_cnt + 1'b1;
              sum_a_q       <= '0;
              sum_b_q       <= '0;
              smp_cnt_q     <= '0;
              // the pending single is served; only a pulse arriving now re-arms it
              single_pend_q <= single;
            end else begin
              sum_a_q   <= sum_a_nxt;
              sum_b_q   <= sum_b_nxt;
              smp_cnt_q <= smp_cnt_q + 1'b1;
            end
            if (gain_req) begin
              state_q <= StAmpWait;
            end else if (grp_last && !run && !single) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StCntWait;
            end
          end
        end

        default: state_q <= StAmpLoad;
      endcase

      if (do_load) begin
        amp_a       <= gain_a;
        amp_b       <= gain_b;
        amp_trig    <= 1'b1;
        gain_pend_q <= 1'b0;
        sum_a_q     <= '0;
        sum_b_q     <= '0;
        smp_cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sampler_ctrl.sv
// Scoreboard bench for adc_sampler_ctrl: directed acquisitions push expected averages, a
// negedge monitor pops and compares on every sample_valid and records strobe timing.
module tb_adc_sampler_ctrl;
  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned CNT_W    = 16;

  logic                CLK50MHZ = 1'b0;
  logic                RST;
  logic                run, single, gain_upd, amp_done, adc_done;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          gain_a, gain_b, amp_a, amp_b;
  logic [13:0]         adc_a, adc_b, sample_a, sample_b;
  logic                amp_trig, adc_trig, sample_valid, overrun, busy;
  logic [CNT_W-1:0]    sample_cnt;

  typedef struct packed {
    logic [13:0]      a;
    logic [13:0]      b;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] adc_qa[$], adc_qb[$];
  int          trig_cyc[$];
  int          n_tests = 0, n_fail = 0, cyc = 0;
  int          n_adc_trig = 0, n_amp_trig = 0, n_valid = 0;
  int          amp_cyc = -1, amp_done_cyc = -1, adc_delay = 3;

  adc_sampler_ctrl #(.PERIOD_W(PERIOD_W), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .run(run), .single(single), .period(period),
    .gain_a(gain_a), .gain_b(gain_b), .gain_upd(gain_upd), .amp_trig(amp_trig),
    .amp_a(amp_a), .amp_b(amp_b), .amp_done(amp_done), .adc_trig(adc_trig),
    .adc_done(adc_done), .adc_a(adc_a), .adc_b(adc_b), .sample_a(sample_a),
    .sample_b(sample_b), .sample_valid(sample_valid), .sample_cnt(sample_cnt),
    .overrun(overrun), .busy(busy)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;
  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK50MHZ);
      if (adc_trig) begin
        n_adc_trig++;
        trig_cyc.push_back(cyc);
      end
      if (amp_trig) begin
        n_amp_trig++;
        amp_cyc = cyc;
      end
      if (sample_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("sample_valid with empty scoreboard", n_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample_a", sample_a, e.a);
          check("sample_b", sample_b, e.b);
          check("sample_cnt", sample_cnt, e.cnt);
        end
      end
    end
  end

  // ADC driver model
  initial begin
    adc_done = 1'b0; adc_a = '0; adc_b = '0;
    forever begin
      @(negedge CLK50MHZ);
      if (adc_trig) begin
        repeat (adc_delay) @(posedge CLK50MHZ);
        #1;
        adc_a    = (adc_qa.size() != 0) ? adc_qa.pop_front() : 14'd0;
        adc_b    = (adc_qb.size() != 0) ? adc_qb.pop_front() : 14'd0;
        adc_done = 1'b1;
        @(posedge CLK50MHZ);
        #1 adc_done = 1'b0;
      end
    end
  end

  // Amp driver model: done 5 clocks after the strobe
  initial begin
    amp_done = 1'b0;
    forever begin
      @(negedge CLK50MHZ);
      if (amp_trig) begin
        repeat (5) @(posedge CLK50MHZ);
        #1 amp_done = 1'b1;
        amp_done_cyc = cyc;
        @(posedge CLK50MHZ);
        #1 amp_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic push(input logic [13:0] a, input logic [13:0] b);
    adc_qa.push_back(a);
    adc_qb.push_back(b);
  endtask

  task automatic wait_done(input int vb, input string tag);
    int k = 0;
    do begin step(); k++; end while (!((n_valid > vb) && !busy) && k < 500);
    check({tag, " completed"}, ((n_valid > vb) && !busy), 1);
  endtask

  // Continuous run for one group of four conversions, then back to IDLE.
  task automatic acquire(input int per, input int dly, input int gap, input string tag);
    int base, vb, run_at, k;
    step();
    base = n_adc_trig; vb = n_valid;
    period = PERIOD_W'(per); adc_delay = dly;
    run = 1'b1; run_at = cyc;
    k = 0;
    while (n_adc_trig < base + 4 && k < 500) begin step(); k++; end
    run = 1'b0;
    wait_done(vb, tag);
    check({tag, " trigger count"}, n_adc_trig - base, 4);
    check({tag, " valid count"}, n_valid - vb, 1);
    if (n_adc_trig >= base + 4) begin
      check({tag, " first trigger delay"}, trig_cyc[base] - run_at, per + 1);
      for (int i = 0; i < 3; i++)
        check({tag, " trigger spacing"}, trig_cyc[base+i+1] - trig_cyc[base+i], gap);
    end
  endtask

  initial begin
    int base, vb, k, amps;
    RST = 1'b1; run = 1'b0; single = 1'b0; gain_upd = 1'b0;
    period = 10; gain_a = 4'd9; gain_b = 4'd9;

    // 1: reset values and initial amp programming
    repeat (3) @(posedge CLK50MHZ);
    @(negedge CLK50MHZ);
    check("reset amp_trig", amp_trig, 0);
    check("reset adc_trig", adc_trig, 0);
    check("reset busy", busy, 0);
    check("reset amp_a", amp_a, 0);
    check("reset sample_cnt", sample_cnt, 0);
    check("reset overrun", overrun, 0);
    check("reset sample_valid", sample_valid, 0);
    step();
    RST = 1'b0;
    k = 0;
    do begin step(); k++; end while (!(n_amp_trig >= 1 && !busy) && k < 100);
    check("amp init amp_a", amp_a, 9);
    check("amp init amp_b", amp_b, 9);
    check("amp init busy", busy, 0);
    check("amp init strobes", n_amp_trig, 1);

    // 2: plain average, period 10
    push(14'd100, 14'h3FCE); push(14'd102, 14'h3FCC);
    push(14'd104, 14'h3FCA); push(14'd106, 14'h3FC8);
    exp_q.push_back('{a: 14'd103, b: 14'h3FCB, cnt: 16'd1});
    acquire(10, 3, 10, "avg");

    // 3: negative samples round toward -inf
    push(14'h3FFF, 14'd5); push(14'h3FFE, 14'd6);
    push(14'h3FFE, 14'd7); push(14'h3FFE, 14'd8);
    exp_q.push_back('{a: 14'h3FFE, b: 14'd6, cnt: 16'd2});
    acquire(10, 3, 10, "neg");
    check("overrun before slow adc", overrun, 0);

    // 4: conversion slower than the period -> overrun, next trigger at the next tick
    push(14'd8, 14'd3); push(14'd8, 14'd2); push(14'd8, 14'd1); push(14'd8, 14'd0);
    exp_q.push_back('{a: 14'd8, b: 14'd1, cnt: 16'd3});
    acquire(4, 6, 8, "ovr");
    check("overrun sticky", overrun, 1);

    // 5: single shot
    push(14'd1, 14'h3FFF); push(14'd2, 14'h3FFF); push(14'd3, 14'h3FFF); push(14'd4, 14'h3FFF);
    exp_q.push_back('{a: 14'd2, b: 14'h3FFF, cnt: 16'd4});
    step();
    base = n_adc_trig; vb = n_valid; period = 10; adc_delay = 3;
    single = 1'b1; k = cyc;
    step();
    single = 1'b0;
    wait_done(vb, "single");
    repeat (30) step();
    check("single trigger count", n_adc_trig - base, 4);
    check("single valid count", n_valid - vb, 1);
    check("single back to idle", busy, 0);
    if (n_adc_trig > base) check("single first trigger", trig_cyc[base] - k, 11);

    // 6: gain update mid-conversion discards the partial group
    push(14'd1000, 14'd1000);
    push(14'd20, 14'h3FF8); push(14'd20, 14'h3FF8); push(14'd20, 14'h3FF8); push(14'd20, 14'h3FF8);
    exp_q.push_back('{a: 14'd20, b: 14'h3FF8, cnt: 16'd5});
    step();
    base = n_adc_trig; vb = n_valid; amps = n_amp_trig;
    run = 1'b1;
    k = 0;
    while (n_adc_trig == base && k < 100) begin step(); k++; end
    gain_a = 4'd5; gain_b = 4'd3; gain_upd = 1'b1;
    step();
    gain_upd = 1'b0;
    k = 0;
    while (n_adc_trig < base + 5 && k < 500) begin step(); k++; end
    run = 1'b0;
    wait_done(vb, "gain");
    check("gain amp strobes", n_amp_trig - amps, 1);
    check("gain amp_a", amp_a, 5);
    check("gain amp_b", amp_b, 3);
    check("gain trigger count", n_adc_trig - base, 5);
    if (n_adc_trig >= base + 5) begin
      check("gain amp_trig after adc_done", amp_cyc - trig_cyc[base], 4);
      check("gain period restart", trig_cyc[base+1] - amp_done_cyc, 11);
      check("gain spacing", trig_cyc[base+4] - trig_cyc[base+1], 30);
    end

    // 7: reset during a conversion
    step();
    vb = n_valid; base = n_adc_trig;
    run = 1'b1;
    k = 0;
    while (n_adc_trig == base && k < 100) begin step(); k++; end
    RST = 1'b1;
    @(negedge CLK50MHZ);
    check("midreset sample_cnt", sample_cnt, 0);
    check("midreset overrun", overrun, 0);
    check("midreset busy", busy, 0);
    run = 1'b0;
    step(); step();
    RST = 1'b0;
    repeat (30) step();
    check("midreset no result", n_valid - vb, 0);
    check("midreset idle", busy, 0);
    check("midreset amp_a", amp_a, 5);
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
